// File: rtl/gf180_ram_pkg.sv
// Shared constants and types for the GF180 512x8 RAM lane and the wider
// bank wrappers built from it.
package gf180_ram_pkg;
  localparam int RAM512X8_ADDR_W = 9;
  localparam int RAM512X8_DATA_W = 8;
  localparam int RAM512X8_DEPTH  = 512;

  typedef logic [RAM512X8_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM512X8_DATA_W-1:0] ram_byte_t;

  // Apply active-low per-bit write enables: a 0 in wen selects the new bit.
  function automatic ram_byte_t ram_merge(input ram_byte_t old_word,
                                          input ram_byte_t wr_data,
                                          input ram_byte_t wen);
    return (wr_data & ~wen) | (old_word & wen);
  endfunction
endpackage

// File: rtl/gf180_ram_512x8_wrapper.sv
// Synchronous single-port 512x8 RAM lane with active-low bit write enables.
// GF180_RAM_WRITE_THROUGH_EN selects post-write Q on write cycles; USE_POWER_PINS adds VDD/VSS.
module gf180_ram_512x8_wrapper
  import gf180_ram_pkg::*;
#(
  parameter INIT_F = ""
) (
`ifdef USE_POWER_PINS
  inout  wire                        VDD,
  inout  wire                        VSS,
`endif
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CEN,
  input  logic                       GWEN,
  input  logic [RAM512X8_DATA_W-1:0] WEN,
  input  logic [RAM512X8_ADDR_W-1:0] A,
  input  logic [RAM512X8_DATA_W-1:0] D,
  output logic [RAM512X8_DATA_W-1:0] Q
);

  ram_byte_t mem [RAM512X8_DEPTH];
  ram_byte_t rd_word;
  ram_byte_t wr_word;
  ram_byte_t q_next;

  always_comb begin
    rd_word = mem[A];
    wr_word = ram_merge(rd_word, D, WEN);
`ifdef GF180_RAM_WRITE_THROUGH_EN
    q_next  = GWEN ? wr_word : rd_word;
`else
    q_next  = rd_word;
`endif
  end

  // Reset only clears Q; the array keeps its contents and the access is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && CEN && GWEN) mem[A] <= wr_word;
  end

  always_ff @(posedge CLK) begin
    if (RST)      Q <= '0;
    else if (CEN) Q <= q_next;
  end

endmodule

// File: tb/tb_gf180_ram_512x8_wrapper.sv
// Self-checking bench: directed vector table, streaming fill/readback and
// randomized traffic against an array-based reference model.
module tb_gf180_ram_512x8_wrapper;
  import gf180_ram_pkg::*;

`ifdef GF180_RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, CEN, GWEN;
  logic [7:0] WEN, D, Q;
  logic [8:0] A;
`ifdef USE_POWER_PINS
  wire VDD = 1'b1;
  wire VSS = 1'b0;
`endif

  gf180_ram_512x8_wrapper dut (
`ifdef USE_POWER_PINS
    .VDD(VDD), .VSS(VSS),
`endif
    .CLK(CLK), .RST(RST), .CEN(CEN), .GWEN(GWEN),
    .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: plain array plus the expected registered output.
  logic [7:0] ref_mem [512];
  logic [7:0] ref_q;

  typedef struct {
    logic       rst, cen, gwen;
    logic [7:0] wen;
    logic [8:0] a;
    logic [7:0] d;
    bit         chk;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic c, logic g, logic [7:0] w,
                              logic [8:0] a, logic [7:0] d, bit chk,
                              logic [7:0] exp, string name);
    vec_t v;
    v.rst = r; v.cen = c; v.gwen = g; v.wen = w;
    v.a = a; v.d = d; v.chk = chk; v.exp = exp; v.name = name;
    return v;
  endfunction

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: Q=%h expected %h", name, act, exp);
    end
  endfunction

  // Apply one cycle of inputs, clock it, update the model, sample 1ns later.
  task automatic step(input logic r, input logic c, input logic g,
                      input logic [7:0] w, input logic [8:0] a, input logic [7:0] d);
    logic [7:0] old_w, new_w;
    RST = r; CEN = c; GWEN = g; WEN = w; A = a; D = d;
    @(posedge CLK);
    if (r) ref_q = 8'h00;
    else if (c) begin
      old_w = ref_mem[a];
      if (g) begin
        new_w = old_w;
        for (int i = 0; i < 8; i++) if (!w[i]) new_w[i] = d[i];
        ref_mem[a] = new_w;
        ref_q = WT ? new_w : old_w;
      end else begin
        ref_q = old_w;
      end
    end
    #1;
  endtask

  initial begin
    RST = 1'b1; CEN = 1'b0; GWEN = 1'b0; WEN = 8'hFF; A = '0; D = '0;
    ref_q = 8'h00;

    // Directed table: reset, full/masked writes, read-during-write, CEN gating.
    vt.push_back(mk(1, 0, 0, 8'hFF, 9'h000, 8'h00, 1, 8'h00, "reset_state"));
    vt.push_back(mk(0, 1, 1, 8'h00, 9'h005, 8'h3C, 0, 8'h00, "prewrite_005"));
    vt.push_back(mk(1, 1, 1, 8'h00, 9'h005, 8'hAA, 1, 8'h00, "rst_blocks_wr0"));
    vt.push_back(mk(1, 1, 1, 8'h00, 9'h005, 8'hAA, 1, 8'h00, "rst_blocks_wr1"));
    vt.push_back(mk(0, 1, 0, 8'h00, 9'h005, 8'h00, 1, 8'h3C, "read_after_rst"));
    vt.push_back(mk(0, 1, 1, 8'h00, 9'h000, 8'hA5, 0, 8'h00, "wr_000"));
    vt.push_back(mk(0, 1, 1, 8'h00, 9'h1FF, 8'hA5, 0, 8'h00, "wr_1ff"));
    vt.push_back(mk(0, 1, 0, 8'hFF, 9'h000, 8'h00, 1, 8'hA5, "rd_000"));
    vt.push_back(mk(0, 1, 0, 8'hFF, 9'h1FF, 8'h00, 1, 8'hA5, "rd_1ff"));
    vt.push_back(mk(0, 1, 1, 8'h00, 9'h010, 8'hFF, 0, 8'h00, "wr_010_ff"));
    vt.push_back(mk(0, 1, 1, 8'hF0, 9'h010, 8'h00, 1, WT ? 8'hF0 : 8'hFF, "mask_wr_q"));
    vt.push_back(mk(0, 1, 0, 8'hFF, 9'h010, 8'h00, 1, 8'hF0, "mask_rd"));
    vt.push_back(mk(0, 1, 1, 8'h00, 9'h020, 8'h11, 0, 8'h00, "wr_020_11"));
    vt.push_back(mk(0, 1, 1, 8'h00, 9'h020, 8'h22, 1, WT ? 8'h22 : 8'h11, "rdw_q"));
    vt.push_back(mk(0, 1, 0, 8'hFF, 9'h020, 8'h00, 1, 8'h22, "rdw_next_rd"));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0, 0, 1, 8'h00, 9'h020, 8'h33, 1, 8'h22, "cen_hold"));
    vt.push_back(mk(0, 1, 0, 8'hFF, 9'h020, 8'h00, 1, 8'h22, "cen_no_wr"));
    vt.push_back(mk(0, 1, 1, 8'hFF, 9'h020, 8'h00, 1, 8'h22, "wen_ff_pure_rd"));
    vt.push_back(mk(0, 1, 0, 8'hFF, 9'h020, 8'h00, 1, 8'h22, "wen_ff_no_wr"));
    vt.push_back(mk(1, 1, 0, 8'hFF, 9'h010, 8'h00, 1, 8'h00, "mid_rst"));
    vt.push_back(mk(0, 1, 0, 8'hFF, 9'h010, 8'h00, 1, 8'hF0, "post_rst_rd"));

    foreach (vt[k]) begin
      step(vt[k].rst, vt[k].cen, vt[k].gwen, vt[k].wen, vt[k].a, vt[k].d);
      if (vt[k].chk) check(vt[k].name, Q, vt[k].exp);
    end

    // Streaming fill then back-to-back readback.
    for (int n = 0; n < 512; n++)
      step(0, 1, 1, 8'h00, 9'(n), 8'(n) ^ 8'h5A);
    for (int n = 0; n < 512; n++) begin
      step(0, 1, 0, 8'hFF, 9'(n), 8'h00);
      check("stream_rd", Q, 8'(n) ^ 8'h5A);
    end

    // Randomized traffic; a small address window forces frequent reuse.
    for (int n = 0; n < 3000; n++) begin
      logic       r, c, g;
      logic [7:0] w;
      logic [8:0] a;
      r = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 3) != 0);
      g = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       w = 8'h00;
        1:       w = 8'hFF;
        default: w = 8'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
      step(r, c, g, w, a, 8'($urandom));
      check("random", Q, ref_q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
